// File: rtl/act_lut_sched.sv
// Activation LUT sequencer: loads the 16-entry table, streams rounded data through the
// external address generator, and returns table/saturated results through a credit-limited FIFO.
module act_lut_sched #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LUT_DEPTH  = 16,
  parameter int unsigned EQ_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cfg_start,
  input  logic [EQ_WIDTH-1:0]   i_cfg_shift,
  input  logic [OUT_WIDTH-1:0]  i_cfg_max,
  input  logic [OUT_WIDTH-1:0]  i_cfg_min,
  input  logic                  i_cfg_wvalid,
  input  logic [OUT_WIDTH-1:0]  i_cfg_wdata,
  output logic                  o_cfg_wready,
  input  logic                  i_run_start,
  input  logic                  i_dat_valid,
  input  logic [DATA_WIDTH-1:0] i_dat,
  input  logic                  i_dat_last,
  output logic                  o_dat_ready,
  output logic [DATA_WIDTH-1:0] o_gen_dat,
  output logic [EQ_WIDTH-1:0]   o_gen_shift,
  input  logic [ADDR_WIDTH-1:0] i_gen_addr,
  input  logic                  i_gen_max_en,
  input  logic                  i_gen_min_en,
  output logic                  o_act_valid,
  output logic [OUT_WIDTH-1:0]  o_act_dat,
  output logic                  o_act_last,
  input  logic                  i_act_ready,
  output logic                  o_busy,
  output logic                  o_lut_loaded,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [EQ_WIDTH-1:0]   MAX_SHIFT = EQ_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LUT_DEPTH - 1);
  localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic [OUT_WIDTH-1:0]  max_q, min_q;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [OUT_WIDTH-1:0]  tbl [LUT_DEPTH];

  logic                  s1_valid, s1_last;
  logic                  s2_valid, s2_last, s2_max, s2_min;
  logic [OUT_WIDTH-1:0]  s2_data;

  logic [OUT_WIDTH-1:0]  fifo_dat  [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count;

  logic                  err_c, done_c, cfg_latch_c, tbl_we_c, xfer_c, push_c, pop_c, cmd_c;
  logic [CNT_W-1:0]      occ_c;
  logic [OUT_WIDTH-1:0]  res_c;

  // Credit: everything already in the FIFO or in flight must fit before a new accept.
  assign occ_c        = count + CNT_W'(s1_valid) + CNT_W'(s2_valid);
  assign o_dat_ready  = (state == RUN) && (occ_c < CNT_W'(FIFO_DEPTH));
  assign o_cfg_wready = (state == LOAD);
  assign o_busy       = (state != IDLE);
  assign xfer_c       = i_dat_valid && o_dat_ready;
  assign tbl_we_c     = i_cfg_wvalid && o_cfg_wready;
  assign cmd_c        = i_cfg_start || i_run_start;
  assign o_gen_dat    = xfer_c ? i_dat : '0;
  assign push_c       = s2_valid;
  assign pop_c        = o_act_valid && i_act_ready;
  assign o_act_valid  = (count != '0);
  assign o_act_dat    = fifo_dat[rd_ptr];
  assign o_act_last   = fifo_last[rd_ptr];
  assign res_c        = s2_max ? max_q : (s2_min ? min_q : s2_data);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    err_c       = 1'b0;
    done_c      = 1'b0;
    cfg_latch_c = 1'b0;
    case (state)
      IDLE: begin
        if (i_cfg_start) begin
          if (i_cfg_shift <= MAX_SHIFT) begin
            cfg_latch_c = 1'b1;
            state_nxt   = LOAD;
          end else begin
            err_c = 1'b1;
          end
        end else if (i_run_start) begin
          if (o_lut_loaded) state_nxt = RUN;
          else              err_c     = 1'b1;
        end
      end
      LOAD: begin
        err_c = cmd_c;
        if (tbl_we_c && (wptr == LAST_ADDR)) state_nxt = IDLE;
      end
      RUN: begin
        err_c = cmd_c;
        if (xfer_c && i_dat_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        err_c = cmd_c;
        if (!s1_valid && !s2_valid && (count == '0)) begin
          state_nxt = IDLE;
          done_c    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration, table and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_gen_shift  <= '0;
      max_q        <= '0;
      min_q        <= '0;
      wptr         <= '0;
      o_lut_loaded <= 1'b0;
      o_err        <= 1'b0;
      o_done       <= 1'b0;
      for (int i = 0; i < LUT_DEPTH; i++) tbl[i] <= '0;
    end else begin
      o_err  <= err_c;
      o_done <= done_c;
      if (cfg_latch_c) begin
        o_gen_shift  <= i_cfg_shift;
        max_q        <= i_cfg_max;
        min_q        <= i_cfg_min;
        wptr         <= '0;
        o_lut_loaded <= 1'b0;
      end else if (tbl_we_c) begin
        tbl[wptr] <= i_cfg_wdata;
        wptr      <= wptr + ADDR_WIDTH'(1);
        if (wptr == LAST_ADDR) o_lut_loaded <= 1'b1;
      end
    end
  end

  // Two tag stages aligned with the generator's registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_max   <= 1'b0;
      s2_min   <= 1'b0;
      s2_data  <= '0;
    end else begin
      s1_valid <= xfer_c;
      s1_last  <= xfer_c && i_dat_last;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_max   <= s1_valid && i_gen_max_en;
      s2_min   <= s1_valid && i_gen_min_en;
      s2_data  <= tbl[i_gen_addr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_dat[i]  <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push_c) begin
        fifo_dat[wr_ptr]  <= res_c;
        fifo_last[wr_ptr] <= s2_last;
        wr_ptr            <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_act_lut_sched.sv
// Bench for act_lut_sched with a behavioural address-generator stub and an output scoreboard.
module tb_act_lut_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_start, cfg_wvalid, cfg_wready, run_start;
  logic [3:0] cfg_shift;
  logic [7:0] cfg_max, cfg_min, cfg_wdata;
  logic       dat_valid, dat_last, dat_ready;
  logic [7:0] dat, gen_dat;
  logic [3:0] gen_shift, gen_addr;
  logic       gen_max_en, gen_min_en;
  logic       act_valid, act_last, act_ready;
  logic [7:0] act_dat;
  logic       busy, lut_loaded, done, err;

  always #5 clk = ~clk;

  act_lut_sched dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_start(cfg_start), .i_cfg_shift(cfg_shift), .i_cfg_max(cfg_max), .i_cfg_min(cfg_min),
    .i_cfg_wvalid(cfg_wvalid), .i_cfg_wdata(cfg_wdata), .o_cfg_wready(cfg_wready),
    .i_run_start(run_start), .i_dat_valid(dat_valid), .i_dat(dat), .i_dat_last(dat_last),
    .o_dat_ready(dat_ready), .o_gen_dat(gen_dat), .o_gen_shift(gen_shift),
    .i_gen_addr(gen_addr), .i_gen_max_en(gen_max_en), .i_gen_min_en(gen_min_en),
    .o_act_valid(act_valid), .o_act_dat(act_dat), .o_act_last(act_last), .i_act_ready(act_ready),
    .o_busy(busy), .o_lut_loaded(lut_loaded), .o_done(done), .o_err(err)
  );

  // Generator stub: arithmetic shift to an address, saturation flags at the input extremes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_addr   <= '0;
      gen_max_en <= 1'b0;
      gen_min_en <= 1'b0;
    end else begin
      gen_addr   <= 4'($signed(gen_dat) >>> gen_shift);
      gen_max_en <= (gen_dat == 8'h7F);
      gen_min_en <= (gen_dat == 8'h80);
    end
  end

  typedef struct packed {
    logic [7:0]  d;
    logic        l;
    logic [31:0] cyc;
  } sb_t;

  sb_t        q[$];
  sb_t        sb_in, sb_out;
  int         nvec = 0, nerr = 0;
  int         cyc = 0;
  bit         chk_lat = 1'b0;
  logic [3:0] m_shift;
  logic [7:0] m_max, m_min;
  logic [7:0] m_tbl [16];

  function automatic logic [7:0] exp_act(input logic [7:0] d);
    int v;
    if (d == 8'h7F) return m_max;
    if (d == 8'h80) return m_min;
    v = int'($signed(d)) / (1 << m_shift);
    if (int'($signed(d)) < 0 && (int'($signed(d)) % (1 << m_shift)) != 0) v = v - 1;
    return m_tbl[v & 15];
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dat_valid && dat_ready) begin
        sb_in.d   = exp_act(dat);
        sb_in.l   = dat_last;
        sb_in.cyc = 32'(cyc);
        q.push_back(sb_in);
      end
      if (act_valid && act_ready) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL sb_unexpected: got dat=%h last=%b, expected no output", act_dat, act_last);
        end else begin
          sb_out = q.pop_front();
          if (act_dat !== sb_out.d || act_last !== sb_out.l) begin
            nerr++;
            $display("FAIL sb_data: got dat=%h last=%b, expected dat=%h last=%b",
                     act_dat, act_last, sb_out.d, sb_out.l);
          end
          if (chk_lat) begin
            nvec++;
            if (32'(cyc) - sb_out.cyc !== 32'd3) begin
              nerr++;
              $display("FAIL latency: got %0d cycles, expected 3", 32'(cyc) - sb_out.cyc);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    bit acc = 1'b0;
    dat_valid = 1'b1;
    dat       = d;
    dat_last  = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = dat_ready;
      step();
      if (acc) break;
    end
    dat_valid = 1'b0;
    dat_last  = 1'b0;
    if (!acc) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout: input %h got no ready, expected acceptance", d);
    end
  endtask

  task automatic start_run();
    run_start = 1'b1;
    step();
    run_start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    nvec++;
    if (!seen || busy !== 1'b0) begin
      nerr++;
      $display("FAIL done_pulse: got seen=%b busy=%b, expected seen=1 busy=0", seen, busy);
    end
    step();
    nvec++;
    if (done !== 1'b0 || q.size() != 0) begin
      nerr++;
      $display("FAIL drain_end: got done=%b pending=%0d, expected done=0 pending=0", done, q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {cfg_start, cfg_wvalid, run_start, dat_valid, dat_last} = '0;
    {cfg_shift, cfg_max, cfg_min, cfg_wdata, dat} = '0;
    act_ready = 1'b1;
    repeat (3) step();
    nvec++;
    if ({cfg_wready, dat_ready, gen_dat, gen_shift, act_valid, act_dat, act_last,
         busy, lut_loaded, done, err} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got busy=%b loaded=%b valid=%b, expected all outputs 0",
               busy, lut_loaded, act_valid);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_errors();
    start_run();
    nvec++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL run_unloaded: got err=%b busy=%b, expected err=1 busy=0", err, busy);
    end
    step();
    nvec++;
    if (err !== 1'b0) begin
      nerr++;
      $display("FAIL err_width: got err=%b, expected 0 one cycle later", err);
    end
    cfg_start = 1'b1;
    cfg_shift = 4'd7;
    cfg_max   = 8'h55;
    step();
    cfg_start = 1'b0;
    nvec++;
    if (err !== 1'b1 || busy !== 1'b0 || gen_shift !== 4'd0) begin
      nerr++;
      $display("FAIL bad_shift: got err=%b busy=%b shift=%0d, expected err=1 busy=0 shift=0",
               err, busy, gen_shift);
    end
    step();
  endtask

  task automatic test_load();
    m_shift = 4'd4;
    m_max   = 8'h7F;
    m_min   = 8'h80;
    cfg_shift = m_shift;
    cfg_max   = m_max;
    cfg_min   = m_min;
    cfg_start = 1'b1;
    run_start = 1'b1;
    step();
    cfg_start = 1'b0;
    run_start = 1'b0;
    nvec++;
    if (busy !== 1'b1 || cfg_wready !== 1'b1 || err !== 1'b0 || gen_shift !== 4'd4) begin
      nerr++;
      $display("FAIL load_enter: got busy=%b wready=%b err=%b shift=%0d, expected 1 1 0 4",
               busy, cfg_wready, err, gen_shift);
    end
    start_run();
    nvec++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL cmd_in_load: got err=%b busy=%b, expected err=1 busy=1", err, busy);
    end
    cfg_wvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cfg_wdata = 8'(i * 3);
      m_tbl[i]  = 8'(i * 3);
      if (i == 15) begin
        nvec++;
        if (busy !== 1'b1 || lut_loaded !== 1'b0) begin
          nerr++;
          $display("FAIL load_before_last: got busy=%b loaded=%b, expected busy=1 loaded=0",
                   busy, lut_loaded);
        end
      end
      step();
    end
    cfg_wvalid = 1'b0;
    nvec++;
    if (busy !== 1'b0 || lut_loaded !== 1'b1 || cfg_wready !== 1'b0) begin
      nerr++;
      $display("FAIL load_done: got busy=%b loaded=%b wready=%b, expected 0 1 0",
               busy, lut_loaded, cfg_wready);
    end
  endtask

  task automatic test_stream();
    chk_lat = 1'b1;
    start_run();
    nvec++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      nerr++;
      $display("FAIL run_enter: got busy=%b err=%b, expected busy=1 err=0", busy, err);
    end
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'hF0, 1'b1);
    nvec++;
    if (dat_ready !== 1'b0) begin
      nerr++;
      $display("FAIL ready_after_last: got %b, expected 0", dat_ready);
    end
    wait_done();
    chk_lat = 1'b0;
  endtask

  task automatic test_saturate();
    start_run();
    send(8'h7F, 1'b0);
    send(8'h80, 1'b0);
    send(8'h70, 1'b1);
    wait_done();
  endtask

  task automatic test_backpressure();
    int n = 0;
    bit a;
    act_ready = 1'b0;
    start_run();
    dat_valid = 1'b1;
    dat       = 8'h30;
    dat_last  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = dat_ready;
      step();
      if (a) begin
        n++;
        dat = dat + 8'd1;
      end
    end
    dat_valid = 1'b0;
    nvec++;
    if (n !== 4) begin
      nerr++;
      $display("FAIL credit_accepts: got %0d accepts, expected 4", n);
    end
    nvec++;
    if (act_valid !== 1'b1 || act_dat !== 8'd9 || act_last !== 1'b0) begin
      nerr++;
      $display("FAIL stall_hold: got valid=%b dat=%h last=%b, expected 1 09 0",
               act_valid, act_dat, act_last);
    end
    act_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h34 + 8'(i), 1'b0);
    send(8'hC5, 1'b1);
    wait_done();
  endtask

  task automatic test_reset_mid();
    act_ready = 1'b0;
    start_run();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({cfg_wready, dat_ready, gen_dat, gen_shift, act_valid, act_dat, act_last,
         busy, lut_loaded, done, err} !== '0) begin
      nerr++;
      $display("FAIL mid_reset: got busy=%b loaded=%b valid=%b dat=%h, expected all outputs 0",
               busy, lut_loaded, act_valid, act_dat);
    end
    q.delete();
    act_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    start_run();
    nvec++;
    if (err !== 1'b1 || busy !== 1'b0 || lut_loaded !== 1'b0) begin
      nerr++;
      $display("FAIL run_after_reset: got err=%b busy=%b loaded=%b, expected 1 0 0",
               err, busy, lut_loaded);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_errors();
    test_load();
    test_stream();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
